// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the stack-machine multicycle controller:
// state codes, opcode values and datapath select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_POP_A    = 4'd3,
    ST_POP_B    = 4'd4,
    ST_ALU_EXEC = 4'd5,
    ST_PUSH_RES = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_PUSH_MEM = 4'd8,
    ST_POP_W    = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_JZ_TEST  = 4'd12,
    ST_ERROR    = 4'd13
  } state_t;

  // Opcode field IR[7:5]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  // Memory address source
  localparam logic ADDR_PC = 1'b0;
  localparam logic ADDR_IR = 1'b1;

  // Next-PC source
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_IR  = 2'b01;

  // Value pushed onto the stack
  localparam logic STK_RES = 1'b0;
  localparam logic STK_MDR = 1'b1;

  // ALU operation, identical to the low two opcode bits of ALU instructions
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags when the allowed wait budget is used up.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_LEN     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  localparam logic [TMR_LEN-1:0] LIMIT = TMR_LEN'(MEM_TIMEOUT);
  localparam logic [TMR_LEN-1:0] ONE   = TMR_LEN'(1);

  logic [TMR_LEN-1:0] count;

  // Wait counter: cleared while not waiting, saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != LIMIT)) begin
      count <= count + ONE;
    end
  end

  assign timeout = (count == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control unit for a small stack machine: Moore state register,
// strobes qualified by opcode, memory handshake and stack status.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       mem_ready,
  input  logic       tos_zero,
  input  logic       stack_empty,
  input  logic       stack_full,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic       push,
  output logic       pop,
  output logic       a_write,
  output logic       b_write,
  output logic       res_write,
  output logic       addr_src,
  output logic [1:0] pc_src,
  output logic       stack_src,
  output logic [1:0] alu_op,
  output logic       halt
);

  state_t state;
  state_t next_state;
  logic   in_wait;
  logic   tmr_clear;
  logic   tmr_count_en;
  logic   timeout;

  // Memory-wait states share one counter; leaving a wait state (mem_ready=1)
  // clears it so the next wait state starts from zero.
  assign in_wait      = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
  assign tmr_clear    = !in_wait || mem_ready;
  assign tmr_count_en = in_wait && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMR_LEN    (TMR_LEN)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .count_en(tmr_count_en),
    .timeout (timeout)
  );

  // State register; reset lands in IDLE so every output drops at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode; stack faults suppress the stack strobe
  always_comb begin
    next_state = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    pc_write   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    a_write    = 1'b0;
    b_write    = 1'b0;
    res_write  = 1'b0;
    addr_src   = ADDR_PC;
    pc_src     = PC_INC;
    stack_src  = STK_RES;
    alu_op     = ALU_ADD;
    halt       = 1'b0;
    case (state)
      ST_IDLE: next_state = ST_FETCH;
      ST_FETCH: begin
        mem_read = 1'b1;
        addr_src = ADDR_PC;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_INC;
          next_state = ST_DECODE;
        end else if (timeout) begin
          next_state = ST_ERROR;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_PUSH: next_state = ST_MEM_RD;
          OP_POP:  next_state = ST_POP_W;
          OP_JMP:  next_state = ST_JUMP;
          OP_JZ:   next_state = ST_JZ_TEST;
          default: next_state = ST_POP_A;
        endcase
      end
      ST_POP_A: begin
        if (stack_empty) begin
          next_state = ST_ERROR;
        end else begin
          pop        = 1'b1;
          a_write    = 1'b1;
          next_state = (opcode == OP_NOT) ? ST_ALU_EXEC : ST_POP_B;
        end
      end
      ST_POP_B: begin
        if (stack_empty) begin
          next_state = ST_ERROR;
        end else begin
          pop        = 1'b1;
          b_write    = 1'b1;
          next_state = ST_ALU_EXEC;
        end
      end
      ST_ALU_EXEC: begin
        alu_op     = opcode[1:0];
        res_write  = 1'b1;
        next_state = ST_PUSH_RES;
      end
      ST_PUSH_RES: begin
        if (stack_full) begin
          next_state = ST_ERROR;
        end else begin
          push       = 1'b1;
          stack_src  = STK_RES;
          next_state = ST_FETCH;
        end
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        addr_src = ADDR_IR;
        if (mem_ready) begin
          mdr_write  = 1'b1;
          next_state = ST_PUSH_MEM;
        end else if (timeout) begin
          next_state = ST_ERROR;
        end
      end
      ST_PUSH_MEM: begin
        if (stack_full) begin
          next_state = ST_ERROR;
        end else begin
          push       = 1'b1;
          stack_src  = STK_MDR;
          next_state = ST_FETCH;
        end
      end
      ST_POP_W: begin
        if (stack_empty) begin
          next_state = ST_ERROR;
        end else begin
          pop        = 1'b1;
          a_write    = 1'b1;
          next_state = ST_MEM_WR;
        end
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        addr_src  = ADDR_IR;
        if (mem_ready) begin
          next_state = ST_FETCH;
        end else if (timeout) begin
          next_state = ST_ERROR;
        end
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_IR;
        next_state = ST_FETCH;
      end
      ST_JZ_TEST: begin
        if (stack_empty) begin
          next_state = ST_ERROR;
        end else begin
          pc_write   = tos_zero;
          pc_src     = PC_IR;
          next_state = ST_FETCH;
        end
      end
      ST_ERROR: halt = 1'b1;
      default:  next_state = ST_ERROR;
    endcase
  end

endmodule
